sram_core: RTL and testbench
============================

Name: sram_core

Overview:
- Single-port, synchronous-write / synchronous-read memory of N words × W bits.
- Accessed through one chip-select and one write-enable.
- Sits beneath the valid/ready SRAM wrapper, which drives cs = addr_val & cmd_val & (wr_val | rd_rdy) and wr_en = cmd.
- After reset, an internal sweep clears every word to zero before accepting accesses.

Parameters:
- N, 4, number of words (depth); any value ≥ 2, not required to be a power of two.
- W, 4, word width in bits.
- A, $clog2(N), address width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge.
- rst  input  1  synchronous, active-high reset.
- cs  input  1  chip select; an access happens only on an edge where cs=1 and the array is not busy.
- wr_en  input  1  1 = write, 0 = read; ignored when cs=0.
- addr  input  A  word address.
- wr_data  input  W  write data.
- rd_data  output  W  registered read data.
- busy  output  1  high while the post-reset clear sweep runs; accesses are ignored while high.

Behaviour:
- Storage: N×W register array plus a two-state controller, INIT and READY, with an A-bit sweep pointer.
- Reset (rst=1 at an edge):
  - rd_data <= 0.
  - State <= INIT, sweep pointer <= 0, busy <= 1.
  - rst takes priority over everything, including a mid-sweep or mid-access cycle; asserting rst again during INIT restarts the sweep at 0.
- INIT:
  - Each edge writes 0 to mem[pointer] and increments the pointer.
  - On the edge that clears word N-1: state <= READY, busy <= 0.
  - busy is high for exactly N cycles after rst deasserts.
  - cs/wr_en/addr/wr_data are ignored; rd_data holds 0.
- READY, cs=1, wr_en=1:
  - mem[addr] <= wr_data at the edge.
  - rd_data holds its previous value; no write-through.
- READY, cs=1, wr_en=0:
  - rd_data <= mem[addr] at the edge.
  - Data is valid from the edge onward (1-cycle latency) and held until the next read or reset.
- READY, cs=0: no array change; rd_data holds.
- Read-after-write: a read at cycle t+1 of an address written at cycle t returns the new data. A single port means there is no same-cycle read/write conflict.
- Out-of-range address (addr ≥ N, possible when N is not a power of two):
  - A write is dropped; the array is unchanged.
  - A read returns all zeros.
- Back-to-back accesses are allowed every cycle; there are no wait states in READY.
- Before the first reset, memory and rd_data are undefined; the bench must apply reset first.
- No combinational path from any input to rd_data or busy.

Decomposition:
- Shared package sram_pkg:
  - State enum: INIT, READY.
  - Default parameter constants: SRAM_DEPTH=4, SRAM_WIDTH=4.
  - A helper function computing the address width.
- One natural sub-module, sram_clear_ctrl: the INIT/READY FSM plus sweep pointer, producing busy, clear_we and clear_addr.
- Top-level muxes sweep writes versus user writes into the array and implements the read register.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, release, cs=0 → busy=1 for exactly 4 cycles then 0; rd_data=0 throughout.
- Write/read all words: write mem[0..3]=4'hA,4'h5,4'hF,4'h3 (cs=1, wr_en=1), then read addr 0..3 back-to-back → rd_data=A,5,F,3, each one edge after its read; rd_data unchanged during the writes.
- Read-after-write and hold: write addr 2 = 4'h7, next cycle read addr 2 → rd_data=7; then cs=0 for 3 cycles → rd_data stays 7; read with cs=0 and wr_en=0 → no change.
- Access during busy: after reset, issue write addr1=4'hC during the INIT cycles; after busy falls, read addr1 → rd_data=0.
- Reset mid-operation: fill memory, pulse rst for 1 cycle, then read all addresses → all 0, and rd_data=0 immediately after the reset edge; pulsing rst again mid-sweep → busy stays high N more cycles.
- Out-of-range (N=5, W=8): write addr 6 = 8'hFF → array unchanged; read addr 6 → 8'h00; addr 4 writes/reads normally.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the single-port SRAM core and its clear controller.
package sram_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_state_e;

  localparam int SRAM_DEPTH = 4;
  localparam int SRAM_WIDTH = 4;

  // Address width for a given depth; depths below 2 still get one address bit.
  function automatic int sram_addr_width(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/sram_clear_ctrl.sv
// Post-reset clear sequencer: sweeps every word to zero, then hands the array to the user port.
module sram_clear_ctrl
  import sram_pkg::*;
#(
  parameter int N = SRAM_DEPTH,
  localparam int A = sram_addr_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  output logic         busy,
  output logic         clear_we,
  output logic [A-1:0] clear_addr
);

  sram_state_e  state_r;
  logic [A-1:0] ptr_r;
  logic         busy_r;
  logic         clear_we_r;

  // INIT/READY state machine with sweep pointer and registered busy/clear strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= INIT;
      ptr_r      <= {A{1'b0}};
      busy_r     <= 1'b1;
      clear_we_r <= 1'b1;
    end else begin
      case (state_r)
        INIT: begin
          if (ptr_r == A'(N - 1)) begin
            state_r    <= READY;
            ptr_r      <= {A{1'b0}};
            busy_r     <= 1'b0;
            clear_we_r <= 1'b0;
          end else begin
            ptr_r <= ptr_r + A'(1);
          end
        end
        READY: begin
          state_r    <= READY;
          busy_r     <= 1'b0;
          clear_we_r <= 1'b0;
        end
        default: begin
          state_r    <= INIT;
          ptr_r      <= {A{1'b0}};
          busy_r     <= 1'b1;
          clear_we_r <= 1'b1;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign clear_we   = clear_we_r;
  assign clear_addr = ptr_r;

endmodule

// File: rtl/sram_core.sv
// Single-port N x W register-array memory with a self-clearing sweep after reset and a registered read port.
module sram_core
  import sram_pkg::*;
#(
  parameter int N = SRAM_DEPTH,
  parameter int W = SRAM_WIDTH,
  localparam int A = sram_addr_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cs,
  input  logic         wr_en,
  input  logic [A-1:0] addr,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         busy
);

  logic [W-1:0] mem_r [N];
  logic [W-1:0] rd_data_r;
  logic         busy_s;
  logic         clear_we_s;
  logic [A-1:0] clear_addr_s;
  logic         addr_ok_s;
  logic         user_we_s;
  logic         user_re_s;
  logic [W-1:0] rd_word_s;

  sram_clear_ctrl #(
    .N (N)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst        (rst),
    .busy       (busy_s),
    .clear_we   (clear_we_s),
    .clear_addr (clear_addr_s)
  );

  // User-port decode; addresses at or above N (non power-of-two depth) never touch the array.
  always_comb begin
    addr_ok_s = (32'(addr) < 32'(N));
    user_we_s = cs && !busy_s && wr_en && addr_ok_s;
    user_re_s = cs && !busy_s && !wr_en;
    if (addr_ok_s) begin
      rd_word_s = mem_r[addr];
    end else begin
      rd_word_s = {W{1'b0}};
    end
  end

  // Array write: the clear sweep owns the array while busy, user writes afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clear_we_s) begin
        mem_r[clear_addr_s] <= {W{1'b0}};
      end else if (user_we_s) begin
        mem_r[addr] <= wr_data;
      end
    end
  end

  // Read register: loads only on a read access and otherwise holds (no write-through).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= {W{1'b0}};
    end else if (user_re_s) begin
      rd_data_r <= rd_word_s;
    end
  end

  assign rd_data = rd_data_r;
  assign busy    = busy_s;

endmodule

// File: tb/tb_sram_core.sv
// Directed scoreboard bench for sram_core: a 4x4 instance and a 5x8 instance for out-of-range addressing.
module tb_sram_core;

  logic       clk;
  logic       rst4, cs4, we4, busy4;
  logic [1:0] addr4;
  logic [3:0] wd4, rd4;
  logic       rst5, cs5, we5, busy5;
  logic [2:0] addr5;
  logic [7:0] wd5, rd5;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] sb_q[$];
  logic [3:0] m4[4];
  logic [7:0] m5[5];
  logic [3:0] last4;
  logic [7:0] last5;

  sram_core #(.N(4), .W(4)) dut4 (
    .clk(clk), .rst(rst4), .cs(cs4), .wr_en(we4), .addr(addr4),
    .wr_data(wd4), .rd_data(rd4), .busy(busy4)
  );

  sram_core #(.N(5), .W(8)) dut5 (
    .clk(clk), .rst(rst5), .cs(cs5), .wr_en(we5), .addr(addr5),
    .wr_data(wd5), .rd_data(rd5), .busy(busy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- 4x4 instance helpers ----------------
  task automatic reset4(input int cycles);
    rst4 = 1'b1;
    repeat (cycles) begin
      tick();
      chk("rst4_rd", 32'(rd4), 32'h0);
      chk("rst4_busy", 32'(busy4), 32'h1);
    end
    rst4 = 1'b0;
    last4 = 4'h0;
    for (int i = 0; i < 4; i++) m4[i] = 4'h0;
  endtask

  task automatic wait4(input string tag);
    int n;
    n = 0;
    while (busy4 !== 1'b0 && n < 50) begin
      chk("init4_rd", 32'(rd4), 32'h0);
      n++;
      tick();
    end
    chk(tag, 32'(n), 32'd4);
  endtask

  task automatic write4(input logic [1:0] a, input logic [3:0] d);
    cs4 = 1'b1; we4 = 1'b1; addr4 = a; wd4 = d;
    tick();
    chk($sformatf("wr4_hold_a%0d", a), 32'(rd4), 32'(last4));
    m4[a] = d;
  endtask

  task automatic read4(input logic [1:0] a);
    logic [7:0] exp;
    cs4 = 1'b1; we4 = 1'b0; addr4 = a;
    sb_q.push_back({4'h0, m4[a]});
    tick();
    exp = sb_q.pop_front();
    chk($sformatf("rd4_a%0d", a), 32'(rd4), 32'(exp));
    last4 = exp[3:0];
  endtask

  task automatic idle4(input int cycles);
    cs4 = 1'b0;
    repeat (cycles) begin
      tick();
      chk("idle4_hold", 32'(rd4), 32'(last4));
    end
  endtask

  // ---------------- 5x8 instance helpers ----------------
  task automatic write5(input logic [2:0] a, input logic [7:0] d);
    cs5 = 1'b1; we5 = 1'b1; addr5 = a; wd5 = d;
    tick();
    chk($sformatf("wr5_hold_a%0d", a), 32'(rd5), 32'(last5));
    if (a < 3'd5) m5[a] = d;
  endtask

  task automatic read5(input logic [2:0] a);
    logic [7:0] exp;
    cs5 = 1'b1; we5 = 1'b0; addr5 = a;
    if (a < 3'd5) sb_q.push_back(m5[a]);
    else sb_q.push_back(8'h00);
    tick();
    exp = sb_q.pop_front();
    chk($sformatf("rd5_a%0d", a), 32'(rd5), 32'(exp));
    last5 = exp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst4 = 1'b0; cs4 = 1'b0; we4 = 1'b0; addr4 = 2'd0; wd4 = 4'h0;
    rst5 = 1'b1; cs5 = 1'b0; we5 = 1'b0; addr5 = 3'd0; wd5 = 8'h00;
    last4 = 4'h0; last5 = 8'h00;

    // Reset then idle: busy high exactly 4 cycles, rd_data 0 throughout
    reset4(2);
    wait4("init4_busy_cycles");
    chk("ready4_busy", 32'(busy4), 32'h0);
    idle4(2);

    // Write all words, then read back-to-back
    write4(2'd0, 4'hA);
    write4(2'd1, 4'h5);
    write4(2'd2, 4'hF);
    write4(2'd3, 4'h3);
    for (int i = 0; i < 4; i++) read4(2'(i));

    // Read-after-write and hold
    write4(2'd2, 4'h7);
    read4(2'd2);
    idle4(3);
    cs4 = 1'b0; we4 = 1'b0; addr4 = 2'd0;
    tick();
    chk("cs0_read_ignored", 32'(rd4), 32'h7);

    // Accesses during the clear sweep are ignored
    cs4 = 1'b1; we4 = 1'b1; addr4 = 2'd1; wd4 = 4'hC;
    reset4(1);
    wait4("init4_busy_cycles_w");
    read4(2'd1);
    read4(2'd0);

    // Reset mid-operation and reset again mid-sweep
    write4(2'd0, 4'h1);
    write4(2'd1, 4'h2);
    write4(2'd2, 4'h4);
    write4(2'd3, 4'h8);
    read4(2'd3);
    cs4 = 1'b0;
    reset4(1);
    tick();
    tick();
    chk("midsweep_busy", 32'(busy4), 32'h1);
    reset4(1);
    wait4("init4_busy_restart");
    for (int i = 0; i < 4; i++) read4(2'(i));

    // Out-of-range addressing on the 5-deep instance
    tick();
    rst5 = 1'b0;
    begin
      int n;
      n = 0;
      while (busy5 !== 1'b0 && n < 50) begin
        n++;
        tick();
      end
      chk("init5_busy_cycles", 32'(n), 32'd5);
    end
    for (int i = 0; i < 5; i++) m5[i] = 8'h00;
    write5(3'd6, 8'hFF);
    write5(3'd4, 8'h5A);
    write5(3'd0, 8'h11);
    write5(3'd7, 8'hEE);
    read5(3'd6);
    read5(3'd4);
    read5(3'd7);
    for (int i = 0; i < 5; i++) read5(3'(i));
    cs5 = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
